// File: rtl/instr_loader_pkg.sv
// Shared decode constants: instruction kinds, opcodes and R-type function codes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: kind_e (request kind encoding), OP_* opcodes, FN_* funct codes, kind_legal().
package instr_loader_pkg;

    // Request kinds as carried on in_kind. Values 16-31 are illegal.
    typedef enum logic [4:0] {
        K_ADD  = 5'd0,
        K_SUB  = 5'd1,
        K_AND  = 5'd2,
        K_OR   = 5'd3,
        K_SLT  = 5'd4,
        K_JR   = 5'd5,
        K_MFHI = 5'd6,
        K_MFLO = 5'd7,
        K_ADDI = 5'd8,
        K_SLTI = 5'd9,
        K_LW   = 5'd10,
        K_SW   = 5'd11,
        K_BEQ  = 5'd12,
        K_BNE  = 5'd13,
        K_J    = 5'd14,
        K_JAL  = 5'd15
    } kind_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SLTI = 6'b000010;
    localparam logic [5:0] OP_LW   = 6'b000011;
    localparam logic [5:0] OP_SW   = 6'b000100;
    localparam logic [5:0] OP_BEQ  = 6'b000101;
    localparam logic [5:0] OP_BNE  = 6'b000110;
    localparam logic [5:0] OP_J    = 6'b000111;
    localparam logic [5:0] OP_JAL  = 6'b001000;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;

    // Kinds 0-15 are defined; anything with bit 4 set is illegal.
    function automatic logic kind_legal(input logic [4:0] kind);
        return !kind[4];
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Request channel (valid/ready) plus instruction-memory write channel (we/ack).
// Latency: n/a (wiring only).
// Backpressure: in_ready throttles requests; mem_ack holds the memory write in place.
// Modports: slave = the loader (consumes requests, issues writes); master = the environment.
interface instr_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_last;

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
        output in_ready,
        output mem_we, mem_addr, mem_wdata,
        input  mem_ack
    );

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
        input  in_ready,
        input  mem_we, mem_addr, mem_wdata,
        output mem_ack
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers; head word visible combinationally on pop_dat.
// Latency: a word pushed at edge N is visible at pop_dat after edge N.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keeps occupancy.
// Ports: clk, rst (async active-low), push/push_dat, pop/pop_dat, empty, full.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = store[rd_ptr];

    // Storage needs no reset: contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/instr_loader.sv
// Encodes instruction requests into 32-bit words and writes them to consecutive memory addresses.
// Latency: word accepted at edge N is offered on mem_we/mem_wdata from edge N+1 onward.
// Backpressure: in_ready drops when the word buffer is full or the last request is taken; mem_ack stalls writes.
// Ports: clk, rst (async active-low), start/base_addr (session control), bus (requests + memory
//        writes), busy/done/err/word_count (status).
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [31:0]    base_addr,
    instr_loader_if.slave  bus,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [15:0]    word_count
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic        last_accepted;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_head;
    logic [31:0] enc_word;
    logic        start_ok;
    logic        accept;
    logic        legal;
    logic        push;
    logic        pop;
    logic [31:0] addr_q;

    assign start_ok = start && (state_q == S_IDLE);
    assign legal    = kind_legal(bus.in_kind);

    assign bus.in_ready = (state_q == S_RUN) && !fifo_full && !last_accepted;
    assign accept       = bus.in_valid && bus.in_ready;
    // Illegal kinds are consumed but never reach the buffer.
    assign push         = accept && legal;

    assign bus.mem_we    = (state_q == S_RUN) && !fifo_empty;
    assign pop           = bus.mem_we && bus.mem_ack;
    // Gate the data so it reads zero whenever no write is offered (including in reset).
    assign bus.mem_wdata = bus.mem_we ? fifo_head : 32'd0;
    assign bus.mem_addr  = addr_q;

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_FIN);

    // Encoder: unused fields are forced to zero for jr/mfhi/mflo.
    always_comb begin
        enc_word = 32'd0;
        case (bus.in_kind)
            K_ADD:   enc_word = {OP_R, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FN_ADD};
            K_SUB:   enc_word = {OP_R, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FN_SUB};
            K_AND:   enc_word = {OP_R, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FN_AND};
            K_OR:    enc_word = {OP_R, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FN_OR};
            K_SLT:   enc_word = {OP_R, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, FN_SLT};
            K_JR:    enc_word = {OP_R, bus.in_rs, 5'd0, 5'd0, 5'd0, FN_JR};
            K_MFHI:  enc_word = {OP_R, 5'd0, 5'd0, bus.in_rd, 5'd0, FN_MFHI};
            K_MFLO:  enc_word = {OP_R, 5'd0, 5'd0, bus.in_rd, 5'd0, FN_MFLO};
            K_ADDI:  enc_word = {OP_ADDI, bus.in_rs, bus.in_rt, bus.in_imm};
            K_SLTI:  enc_word = {OP_SLTI, bus.in_rs, bus.in_rt, bus.in_imm};
            K_LW:    enc_word = {OP_LW, bus.in_rs, bus.in_rt, bus.in_imm};
            K_SW:    enc_word = {OP_SW, bus.in_rs, bus.in_rt, bus.in_imm};
            K_BEQ:   enc_word = {OP_BEQ, bus.in_rs, bus.in_rt, bus.in_imm};
            K_BNE:   enc_word = {OP_BNE, bus.in_rs, bus.in_rt, bus.in_imm};
            K_J:     enc_word = {OP_J, bus.in_target};
            K_JAL:   enc_word = {OP_JAL, bus.in_target};
            default: enc_word = 32'd0;
        endcase
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (enc_word),
        .pop      (pop),
        .pop_dat  (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Session ends only once the last request is in and every buffered word has been acked.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_RUN;
            S_RUN:   if (last_accepted && fifo_empty) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q        <= 32'd0;
            word_count    <= 16'd0;
            err           <= 1'b0;
            last_accepted <= 1'b0;
        end else if (start_ok) begin
            addr_q        <= base_addr;
            word_count    <= 16'd0;
            err           <= 1'b0;
            last_accepted <= 1'b0;
        end else begin
            if (pop) begin
                addr_q     <= addr_q + 32'd4;
                word_count <= word_count + 16'd1;
            end
            if (accept && !legal) begin
                err <= 1'b1;
            end
            if (accept && bus.in_last) begin
                last_accepted <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;
    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] word_count;
    logic        ack_en;

    int checks;
    int failures;
    int done_cnt;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_dat_q[$];

    instr_loader_if bus();

    instr_loader #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    assign bus.mem_ack = ack_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory and done monitors.
    always @(posedge clk) begin
        if (bus.mem_we && bus.mem_ack) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_dat_q.push_back(bus.mem_wdata);
        end
        if (done) done_cnt++;
    end

    task automatic do_start(input logic [31:0] addr);
        @(negedge clk);
        start = 1'b1;
        base_addr = addr;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic last, output logic ok);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_kind = k;
        bus.in_rs = rs;
        bus.in_rt = rt;
        bus.in_rd = rd;
        bus.in_imm = imm;
        bus.in_target = tgt;
        bus.in_last = last;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic wait_done(output logic ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'd0) begin failures++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'd0) begin failures++; $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (word_count !== 16'd0) begin failures++; $display("FAIL reset_word_count got %0d want 0", word_count); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        // ack while idle must do nothing
        ack_en = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (word_count !== 16'd0) begin failures++; $display("FAIL idle_ack_count got %0d want 0", word_count); end
        checks++; if (bus.mem_addr !== 32'd0) begin failures++; $display("FAIL idle_ack_addr got %h want 0", bus.mem_addr); end
        checks++; if (wr_addr_q.size() !== 0) begin failures++; $display("FAIL idle_ack_writes got %0d want 0", wr_addr_q.size()); end
    endtask

    task automatic test_single();
        logic ok;
        wr_addr_q.delete(); wr_dat_q.delete();
        ack_en = 1'b1;
        do_start(32'h40);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got %b want 1", busy); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL single_we_early got %b want 0", bus.mem_we); end
        send(5'd8, 5'd1, 5'd2, 5'd0, 16'h0005, 26'd0, 1'b1, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_accept timeout got %b want 1", ok); end
        wait_done(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_done timeout got %b want 1", ok); end
        checks++; if (wr_addr_q.size() !== 1) begin failures++; $display("FAIL single_nwrites got %0d want 1", wr_addr_q.size()); end
        if (wr_addr_q.size() >= 1) begin
            checks++; if (wr_addr_q[0] !== 32'h40) begin failures++; $display("FAIL single_addr got %h want 00000040", wr_addr_q[0]); end
            checks++; if (wr_dat_q[0] !== 32'h04220005) begin failures++; $display("FAIL single_data got %h want 04220005", wr_dat_q[0]); end
        end
        checks++; if (word_count !== 16'd1) begin failures++; $display("FAIL single_word_count got %0d want 1", word_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got %b want 0", busy); end
    endtask

    task automatic test_two();
        logic ok;
        wr_addr_q.delete(); wr_dat_q.delete();
        ack_en = 1'b1;
        do_start(32'h100);
        send(5'd0, 5'd3, 5'd4, 5'd5, 16'h0000, 26'd0, 1'b0, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL two_accept0 timeout got %b want 1", ok); end
        send(5'd15, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h10, 1'b1, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL two_accept1 timeout got %b want 1", ok); end
        wait_done(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL two_done timeout got %b want 1", ok); end
        checks++; if (wr_addr_q.size() !== 2) begin failures++; $display("FAIL two_nwrites got %0d want 2", wr_addr_q.size()); end
        if (wr_addr_q.size() >= 2) begin
            checks++; if (wr_dat_q[0] !== 32'h00642820) begin failures++; $display("FAIL two_data0 got %h want 00642820", wr_dat_q[0]); end
            checks++; if (wr_dat_q[1] !== 32'h20000010) begin failures++; $display("FAIL two_data1 got %h want 20000010", wr_dat_q[1]); end
            checks++; if (wr_addr_q[1] !== 32'h104) begin failures++; $display("FAIL two_addr1 got %h want 00000104", wr_addr_q[1]); end
        end
        checks++; if (word_count !== 16'd2) begin failures++; $display("FAIL two_word_count got %0d want 2", word_count); end
    endtask

    task automatic test_backpressure();
        logic ok;
        int idx;
        int acc;
        wr_addr_q.delete(); wr_dat_q.delete();
        ack_en = 1'b0;
        do_start(32'h200);
        idx = 0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            if (idx < 6) begin
                bus.in_valid = 1'b1;
                bus.in_kind = 5'd8;
                bus.in_rs = 5'd1;
                bus.in_rt = 5'd2;
                bus.in_rd = 5'd0;
                bus.in_imm = 16'(idx);
                bus.in_target = 26'd0;
                bus.in_last = (idx == 5);
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) begin
                acc++;
                idx++;
            end
            @(negedge clk);
        end
        checks++; if (acc !== 4) begin failures++; $display("FAIL bp_accepted got %0d want 4", acc); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
        checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL bp_mem_we got %b want 1", bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'h200) begin failures++; $display("FAIL bp_hold_addr got %h want 00000200", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h04220000) begin failures++; $display("FAIL bp_hold_data got %h want 04220000", bus.mem_wdata); end
        checks++; if (wr_addr_q.size() !== 0) begin failures++; $display("FAIL bp_no_writes got %0d want 0", wr_addr_q.size()); end
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        ack_en = 1'b1;
        send(5'd8, 5'd1, 5'd2, 5'd0, 16'd4, 26'd0, 1'b0, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_accept4 timeout got %b want 1", ok); end
        send(5'd8, 5'd1, 5'd2, 5'd0, 16'd5, 26'd0, 1'b1, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_accept5 timeout got %b want 1", ok); end
        wait_done(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_done timeout got %b want 1", ok); end
        checks++; if (wr_addr_q.size() !== 6) begin failures++; $display("FAIL bp_nwrites got %0d want 6", wr_addr_q.size()); end
        for (int i = 0; i < 6 && i < wr_addr_q.size(); i++) begin
            checks++; if (wr_addr_q[i] !== 32'h200 + 32'(4 * i)) begin failures++; $display("FAIL bp_addr%0d got %h want %h", i, wr_addr_q[i], 32'h200 + 32'(4 * i)); end
            checks++; if (wr_dat_q[i] !== 32'h04220000 + 32'(i)) begin failures++; $display("FAIL bp_data%0d got %h want %h", i, wr_dat_q[i], 32'h04220000 + 32'(i)); end
        end
        checks++; if (word_count !== 16'd6) begin failures++; $display("FAIL bp_word_count got %0d want 6", word_count); end
    endtask

    task automatic test_illegal();
        logic ok;
        wr_addr_q.delete(); wr_dat_q.delete();
        ack_en = 1'b1;
        do_start(32'h300);
        send(5'h1F, 5'd1, 5'd1, 5'd1, 16'hFFFF, 26'd0, 1'b0, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ill_accept timeout got %b want 1", ok); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_err got %b want 1", err); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL ill_no_we got %b want 0", bus.mem_we); end
        send(5'd11, 5'd2, 5'd3, 5'd0, 16'h0008, 26'd0, 1'b1, ok);
        wait_done(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ill_done timeout got %b want 1", ok); end
        checks++; if (wr_addr_q.size() !== 1) begin failures++; $display("FAIL ill_nwrites got %0d want 1", wr_addr_q.size()); end
        if (wr_addr_q.size() >= 1) begin
            checks++; if (wr_addr_q[0] !== 32'h300) begin failures++; $display("FAIL ill_addr got %h want 00000300", wr_addr_q[0]); end
            checks++; if (wr_dat_q[0] !== 32'h10430008) begin failures++; $display("FAIL ill_data got %h want 10430008", wr_dat_q[0]); end
        end
        checks++; if (word_count !== 16'd1) begin failures++; $display("FAIL ill_word_count got %0d want 1", word_count); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_err_sticky got %b want 1", err); end
        // next start clears err and count; finish with a full-width j target
        wr_addr_q.delete(); wr_dat_q.delete();
        do_start(32'h400);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL ill_err_cleared got %b want 0", err); end
        checks++; if (word_count !== 16'd0) begin failures++; $display("FAIL ill_count_cleared got %0d want 0", word_count); end
        send(5'd14, 5'd0, 5'd0, 5'd0, 16'd0, 26'h3FFFFFF, 1'b1, ok);
        wait_done(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL j_done timeout got %b want 1", ok); end
        if (wr_dat_q.size() >= 1) begin
            checks++; if (wr_dat_q[0] !== 32'h1FFFFFFF) begin failures++; $display("FAIL j_data got %h want 1fffffff", wr_dat_q[0]); end
        end else begin
            checks++; failures++; $display("FAIL j_nwrites got 0 want 1");
        end
    endtask

    task automatic test_reset_midwrite();
        logic ok;
        wr_addr_q.delete(); wr_dat_q.delete();
        ack_en = 1'b0;
        do_start(32'h500);
        send(5'd10, 5'd1, 5'd2, 5'd0, 16'hFFFC, 26'd0, 1'b0, ok);
        checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL rmw_we_before got %b want 1", bus.mem_we); end
        checks++; if (bus.mem_wdata !== 32'h0C22FFFC) begin failures++; $display("FAIL rmw_data_before got %h want 0c22fffc", bus.mem_wdata); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rmw_we_async got %b want 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'd0) begin failures++; $display("FAIL rmw_addr_async got %h want 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'd0) begin failures++; $display("FAIL rmw_wdata_async got %h want 0", bus.mem_wdata); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmw_busy_async got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b1;
        ack_en = 1'b1;
        do_start(32'h600);
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rmw_fifo_empty got %b want 0", bus.mem_we); end
        send(5'd12, 5'd4, 5'd5, 5'd0, 16'h0010, 26'd0, 1'b1, ok);
        wait_done(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rmw_done timeout got %b want 1", ok); end
        checks++; if (wr_addr_q.size() !== 1) begin failures++; $display("FAIL rmw_nwrites got %0d want 1", wr_addr_q.size()); end
        if (wr_addr_q.size() >= 1) begin
            checks++; if (wr_addr_q[0] !== 32'h600) begin failures++; $display("FAIL rmw_addr got %h want 00000600", wr_addr_q[0]); end
            checks++; if (wr_dat_q[0] !== 32'h14850010) begin failures++; $display("FAIL rmw_data got %h want 14850010", wr_dat_q[0]); end
        end
    endtask

    task automatic test_start_ignored();
        logic ok;
        wr_addr_q.delete(); wr_dat_q.delete();
        ack_en = 1'b1;
        do_start(32'h700);
        send(5'd1, 5'd6, 5'd7, 5'd8, 16'd0, 26'd0, 1'b0, ok);
        do_start(32'h900);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sti_busy got %b want 1", busy); end
        send(5'd5, 5'd31, 5'd3, 5'd4, 16'hFFFF, 26'd0, 1'b0, ok);
        send(5'd6, 5'd1, 5'd2, 5'd9, 16'hFFFF, 26'd0, 1'b1, ok);
        wait_done(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL sti_done timeout got %b want 1", ok); end
        checks++; if (wr_addr_q.size() !== 3) begin failures++; $display("FAIL sti_nwrites got %0d want 3", wr_addr_q.size()); end
        if (wr_addr_q.size() >= 3) begin
            checks++; if (wr_dat_q[0] !== 32'h00C74022) begin failures++; $display("FAIL sti_data0 got %h want 00c74022", wr_dat_q[0]); end
            checks++; if (wr_dat_q[1] !== 32'h03E00008) begin failures++; $display("FAIL sti_data1 got %h want 03e00008", wr_dat_q[1]); end
            checks++; if (wr_dat_q[2] !== 32'h00004810) begin failures++; $display("FAIL sti_data2 got %h want 00004810", wr_dat_q[2]); end
            checks++; if (wr_addr_q[2] !== 32'h708) begin failures++; $display("FAIL sti_addr2 got %h want 00000708", wr_addr_q[2]); end
        end
        checks++; if (word_count !== 16'd3) begin failures++; $display("FAIL sti_word_count got %0d want 3", word_count); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        done_cnt = 0;
        rst = 1'b0;
        start = 1'b0;
        base_addr = 32'd0;
        ack_en = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_kind = 5'd0;
        bus.in_rs = 5'd0;
        bus.in_rt = 5'd0;
        bus.in_rd = 5'd0;
        bus.in_imm = 16'd0;
        bus.in_target = 26'd0;
        bus.in_last = 1'b0;
        test_reset();
        test_single();
        test_two();
        test_backpressure();
        test_illegal();
        test_reset_midwrite();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning encoded-word buffer entries (power of two, >=2).
REQ-002 SHALL have ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  reset; asynchronous assert, active-low.
- start  input  1  one-cycle pulse that begins a load session.
- base_addr  input  32  first instruction-memory byte address, sampled on start.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_kind  input  5  instruction kind (package enum); 0-15 legal.
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_imm  input  16  I-type immediate.
- in_target  input  26  J-type target.
- in_last  input  1  marks the final request of the session.
- mem_we  output  1  instruction-memory write request.
- mem_addr  output  32  write byte address.
- mem_wdata  output  32  encoded instruction word.
- mem_ack  input  1  memory accepted the current write.
- busy  output  1  session active.
- done  output  1  one-cycle pulse at session end.
- err  output  1  sticky illegal-kind flag.
- word_count  output  16  words written this session.

Function
REQ-003 SHALL encode opcode[31:26]: R=000000, addi=000001, slti=000010, lw=000011, sw=000100, beq=000101, bne=000110, j=000111, jal=001000.
REQ-004 SHALL encode R-type as rs[25:21], rt[20:16], rd[15:11], shamt=0, funct[5:0]: add 100000, sub 100010, and 100100, or 100101, slt 101010, jr 001000, mfhi 010000, mflo 010010.
REQ-005 SHALL zero unused fields: jr keeps rs only; mfhi/mflo keep rd only.
REQ-006 SHALL encode I-type as rs, rt, imm[15:0]; J-type as target[25:0].
REQ-007 SHALL implement FSM IDLE -> RUN on start; RUN -> FIN when last request has been accepted, FIFO is empty and no write is pending; FIN -> IDLE unconditionally; done=1 only in FIN.
REQ-008 SHALL ignore start outside IDLE; on accepted start, load mem_addr=base_addr, clear word_count and err.
REQ-009 SHALL drive in_ready = (state==RUN) && !fifo_full && !last_accepted.
REQ-010 SHALL encode at acceptance and push the 32-bit word into the FIFO in the same edge; a word accepted at cycle N SHALL appear on mem_we/mem_wdata no earlier than N+1.
REQ-011 SHALL present the FIFO head with mem_we=1 whenever the FIFO is non-empty in RUN, holding mem_addr/mem_wdata stable until mem_ack is sampled high.
REQ-012 SHALL, on mem_we && mem_ack, pop the head, add 4 to mem_addr, increment word_count (wraps at 2^16), and present the next word in the following cycle (back-to-back allowed).
REQ-013 SHALL accept illegal kinds (16-31): set err, write nothing, and still honour in_last.
REQ-014 SHALL allow push and pop in the same cycle; occupancy unchanged.
REQ-015 SHALL drive busy=1 in RUN and FIN.
REQ-016 SHALL ignore mem_ack while mem_we=0.

Reset
REQ-017 SHALL, on rst low at any time including mid-write, force immediately: state IDLE, FIFO empty, mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0, busy=0, done=0, err=0, word_count=0.
REQ-018 SHALL resume normal operation on the first clk edge after rst deasserts.

Structure
REQ-019 SHALL place the in_kind enum, opcode constants and funct constants in a shared package that the decode-side controller also uses.
REQ-020 SHALL implement the buffer as one sub-module, sync_fifo (parameters WIDTH=32, DEPTH=FIFO_DEPTH); the encoder SHALL be combinational logic inside instr_loader.

Verification
REQ-021 Start base_addr=0x40; push addi rs=1 rt=2 imm=0x0005 with in_last; ack high -> write 0x04220005 at 0x40, done pulse, word_count=1.
REQ-022 Push add rs=3 rt=4 rd=5, then jal target=0x10 -> words 0x00642820 then 0x20000010 at base, base+4.
REQ-023 Hold mem_ack=0 for 10 cycles while offering 6 requests -> exactly 4 accepted, in_ready=0 afterwards; releasing ack writes them in order at consecutive +4 addresses.
REQ-024 Push in_kind=0x1F then sw -> err=1, only the sw word is written, word_count=1, err cleared by the next start.
REQ-025 Drive rst low while mem_we=1 -> mem_we=0 with no clock edge; after release FSM is IDLE, FIFO empty, start works normally.
REQ-026 Pulse start during RUN with a different base_addr -> ignored; addresses continue from the original base.
